// File: rtl/max7219_chain_if.sv
// Frame handshake between display-content logic and the MAX7219 chain driver.
// The producer drives a whole frame plus intensity and holds it until acked.
interface max7219_chain_if #(
    parameter int DEVICES = 4
);
    logic [DEVICES*64-1:0] in_data;
    logic                  in_valid;
    logic                  in_ack;
    logic [3:0]            in_intensity;

    modport master (
        output in_data,
        output in_valid,
        output in_intensity,
        input  in_ack
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_intensity,
        output in_ack
    );
endinterface

// File: rtl/max7219_chain.sv
// Serial driver for a daisy chain of MAX7219 8x8 LED drivers (config, then rows).
// Optional MAX7219_REINIT_EN: re-send the full config sequence before every frame.
module max7219_chain #(
    parameter int DEVICES       = 4,
    parameter int CLOCK_DIVIDER = 2,
    parameter int INTENSITY_W   = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    max7219_chain_if.slave bus,
    output logic           busy,
    output logic           out_data,
    output logic           out_clock,
    output logic           out_load
);
    localparam int N  = DEVICES * 16;
    localparam int BW = $clog2(N + 1);
    localparam int DW = $clog2(CLOCK_DIVIDER + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDER - 1);

    typedef enum logic [1:0] {
        S_INIT, S_IDLE, S_INTEN, S_ROW
    } state_t;

    typedef enum logic [2:0] {
        P_HOLD, P_LOW, P_HIGH, P_LOAD, P_GAP
    } phase_t;

    state_t                 state;
    phase_t                 phase;
    logic [DW-1:0]          div;
    logic [BW-1:0]          bits;
    logic [N-1:0]           sreg;
    logic [2:0]             cfg_idx;
    logic [2:0]             row;
    logic [DEVICES*64-1:0]  snap;
    logic [INTENSITY_W-1:0] snap_int;
    logic [INTENSITY_W-1:0] last_int;
`ifdef MAX7219_REINIT_EN
    logic                   frame_on;
`endif

    logic                   launch;
    logic [N-1:0]           lw;
    state_t                 ls;
    logic [2:0]             lcfg;
    logic [2:0]             lrow;
    logic                   lint_wr;
    logic [INTENSITY_W-1:0] lint_val;

    function automatic logic [N-1:0] cfg_word(
        input logic [2:0]             idx,
        input logic [INTENSITY_W-1:0] i
    );
        logic [15:0] w;
        w = 16'h0C01;
        unique case (idx)
            3'd0:    w = 16'h0F00;
            3'd1:    w = 16'h0900;
            3'd2:    w = 16'h0B07;
            3'd3:    w = {8'h0A, 8'(i)};
            default: w = 16'h0C01;
        endcase
        return {DEVICES{w}};
    endfunction

    // Device 0 sits in the low word so it leaves the shifter last.
    function automatic logic [N-1:0] row_word(
        input logic [DEVICES*64-1:0] f,
        input logic [2:0]            r
    );
        logic [N-1:0] w;
        w = '0;
        for (int d = 0; d < DEVICES; d++) begin
            w[d*16 +: 16] = {4'h0, {1'b0, r} + 4'd1,
                             f[d*64 + int'(r)*8 +: 8]};
        end
        return w;
    endfunction

    assign bus.in_ack = (state == S_IDLE) && (phase == P_HOLD)
                        && bus.in_valid;

    // Picks the next transaction at boot, at frame capture or after a gap.
    always_comb begin
        launch   = 1'b0;
        lw       = '0;
        ls       = state;
        lcfg     = cfg_idx;
        lrow     = row;
        lint_wr  = 1'b0;
        lint_val = snap_int;
        if (phase == P_HOLD) begin
            if (state == S_INIT) begin
                launch = 1'b1;
                lcfg   = 3'd0;
                lw     = cfg_word(3'd0, bus.in_intensity);
            end else if (state == S_IDLE && bus.in_valid) begin
                launch = 1'b1;
`ifdef MAX7219_REINIT_EN
                ls   = S_INIT;
                lcfg = 3'd0;
                lw   = cfg_word(3'd0, bus.in_intensity);
`else
                if (bus.in_intensity != last_int) begin
                    ls       = S_INTEN;
                    lw       = cfg_word(3'd3, bus.in_intensity);
                    lint_wr  = 1'b1;
                    lint_val = bus.in_intensity;
                end else begin
                    ls   = S_ROW;
                    lrow = 3'd0;
                    lw   = row_word(bus.in_data, 3'd0);
                end
`endif
            end
        end else if (phase == P_GAP) begin
            unique case (state)
                S_INIT: begin
                    if (cfg_idx != 3'd4) begin
                        launch  = 1'b1;
                        lcfg    = cfg_idx + 3'd1;
                        lw      = cfg_word(cfg_idx + 3'd1, snap_int);
                        lint_wr = (cfg_idx == 3'd2);
                    end
`ifdef MAX7219_REINIT_EN
                    else if (frame_on) begin
                        launch = 1'b1;
                        ls     = S_ROW;
                        lrow   = 3'd0;
                        lw     = row_word(snap, 3'd0);
                    end
`endif
                end
                S_INTEN: begin
                    launch = 1'b1;
                    ls     = S_ROW;
                    lrow   = 3'd0;
                    lw     = row_word(snap, 3'd0);
                end
                S_ROW: begin
                    if (row != 3'd7) begin
                        launch = 1'b1;
                        lrow   = row + 3'd1;
                        lw     = row_word(snap, row + 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            phase     <= P_HOLD;
            div       <= '0;
            bits      <= '0;
            sreg      <= '0;
            cfg_idx   <= '0;
            row       <= '0;
            snap      <= '0;
            snap_int  <= '0;
            last_int  <= '0;
            busy      <= 1'b1;
            out_data  <= 1'b0;
            out_clock <= 1'b0;
            out_load  <= 1'b0;
`ifdef MAX7219_REINIT_EN
            frame_on  <= 1'b0;
`endif
        end else begin
            if (lint_wr) last_int <= lint_val;
            if (phase == P_HOLD && launch) snap_int <= bus.in_intensity;
            if (state == S_IDLE && launch) begin
                snap <= bus.in_data;
`ifdef MAX7219_REINIT_EN
                frame_on <= 1'b1;
`endif
            end
            unique case (phase)
                P_HOLD, P_GAP: begin
                    if (launch) begin
                        state    <= ls;
                        cfg_idx  <= lcfg;
                        row      <= lrow;
                        sreg     <= lw;
                        out_data <= lw[N-1];
                        div      <= '0;
                        bits     <= '0;
                        phase    <= P_LOW;
                        busy     <= 1'b1;
                    end else if (phase == P_GAP) begin
                        state <= S_IDLE;
                        phase <= P_HOLD;
                        busy  <= 1'b0;
`ifdef MAX7219_REINIT_EN
                        frame_on <= 1'b0;
`endif
                    end
                end
                P_LOW: begin
                    if (div == DIV_LAST) begin
                        div       <= '0;
                        out_clock <= 1'b1;
                        phase     <= P_HIGH;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                P_HIGH: begin
                    if (div == DIV_LAST) begin
                        div       <= '0;
                        out_clock <= 1'b0;
                        if (bits == BIT_LAST) begin
                            out_data <= 1'b0;
                            out_load <= 1'b1;
                            phase    <= P_LOAD;
                        end else begin
                            bits     <= bits + BW'(1);
                            sreg     <= {sreg[N-2:0], 1'b0};
                            out_data <= sreg[N-2];
                            phase    <= P_LOW;
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                P_LOAD: begin
                    if (div == DIV_LAST) begin
                        div      <= '0;
                        out_load <= 1'b0;
                        phase    <= P_GAP;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: phase <= P_HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_max7219_chain.sv
// Directed bench for max7219_chain with DEVICES=2, CLOCK_DIVIDER=2.
// Decodes the serial pins back into 32-bit chain words at each LOAD pulse.
module tb_max7219_chain;
    localparam int DEV = 2;
    localparam int TXN = 131;
`ifdef MAX7219_REINIT_EN
    localparam int PRE = 5;
`else
    localparam int PRE = 0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy, out_data, out_clock, out_load;

    max7219_chain_if #(.DEVICES(DEV)) bus ();

    max7219_chain #(.DEVICES(DEV), .CLOCK_DIVIDER(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .busy      (busy),
        .out_data  (out_data),
        .out_clock (out_clock),
        .out_load  (out_load)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    logic [31:0] q[$];
    logic [31:0] mon_sr = '0;
    int mon_bits = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge out_clock or posedge out_load or negedge reset_n) begin
        if (!reset_n) begin
            mon_bits = 0;
        end else if (out_load) begin
            chk("load_bits", 32'(mon_bits), 32'd32);
            q.push_back(mon_sr);
            mon_bits = 0;
        end else if (out_clock) begin
            mon_sr = {mon_sr[30:0], out_data};
            mon_bits++;
        end
    end

    typedef struct {
        logic [127:0] data;
        logic [3:0]   inten;
        bit           exp_inten;
        logic [31:0]  exp_row1;
        logic [31:0]  exp_row8;
    } vec_t;

    vec_t vecs[4];

    task automatic start_frame(input logic [127:0] d, input logic [3:0] i);
        bus.in_data      = d;
        bus.in_intensity = i;
        bus.in_valid     = 1'b1;
        @(negedge clock);
        chk("ack_pulse", 32'(bus.in_ack), 32'd1);
        q.delete();
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        chk("busy_set", 32'(busy), 32'd1);
        chk("ack_drop", 32'(bus.in_ack), 32'd0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 6000) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic check_init(input logic [3:0] i);
        int cyc;
        @(posedge clock);
        wait_idle(cyc);
        chk("init_cycles", 32'(cyc), 32'd655);
        chk("init_loads", 32'(q.size()), 32'd5);
        chk("cfg_test", q[0], 32'h0F000F00);
        chk("cfg_decode", q[1], 32'h09000900);
        chk("cfg_scan", q[2], 32'h0B070B07);
        chk("cfg_inten", q[3], {8'h0A, 4'h0, i, 8'h0A, 4'h0, i});
        chk("cfg_normal", q[4], 32'h0C010C01);
    endtask

    initial begin
        int cyc;
        int loads;
        int acks;
        vecs[0] = '{{64'h1100_0000_0000_00A5, 64'h2200_0000_0000_003C},
                    4'h3, 1'b0, 32'h01A5013C, 32'h08110822};
        vecs[1] = '{{64'h1100_0000_0000_00A5, 64'h2200_0000_0000_003C},
                    4'h9, 1'b1, 32'h01A5013C, 32'h08110822};
        vecs[2] = '{{64'hFF00_0000_0000_0001, 64'h8000_0000_0000_0000},
                    4'h9, 1'b0, 32'h01010100, 32'h08FF0880};
        vecs[3] = '{128'h0, 4'h0, 1'b1, 32'h01000100, 32'h08000800};

        bus.in_data      = '0;
        bus.in_valid     = 1'b1;
        bus.in_intensity = 4'h3;
        repeat (3) @(negedge clock);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_clock", 32'(out_clock), 32'd0);
        chk("rst_load", 32'(out_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ack", 32'(bus.in_ack), 32'd0);
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        check_init(4'h3);

        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].data, vecs[v].inten);
            wait_idle(cyc);
`ifdef MAX7219_REINIT_EN
            loads = 13;
            chk("reinit_first", q[0], 32'h0F000F00);
            chk("reinit_inten", q[3], {2{8'h0A, 4'h0, vecs[v].inten}});
`else
            loads = 8 + int'(vecs[v].exp_inten);
            if (vecs[v].exp_inten)
                chk("inten_word", q[0], {2{8'h0A, 4'h0, vecs[v].inten}});
`endif
            chk("frame_loads", 32'(q.size()), 32'(loads));
            chk("frame_cycles", 32'(cyc), 32'(loads * TXN));
            chk("row1_word", q[q.size() - 8], vecs[v].exp_row1);
            chk("row8_word", q[q.size() - 1], vecs[v].exp_row8);
        end

        // New frame offered while the previous one is still shifting out.
        start_frame(vecs[0].data, 4'h0);
        repeat (300) @(posedge clock);
        #1;
        bus.in_data  = vecs[2].data;
        bus.in_valid = 1'b1;
        acks = 0;
        cyc  = 0;
        while (busy && cyc < 6000) begin
            @(posedge clock);
            #1;
            cyc++;
            if (busy && bus.in_ack) acks++;
        end
        chk("held_no_ack", 32'(acks), 32'd0);
        chk("held_ack_idle", 32'(bus.in_ack), 32'd1);
        chk("old_loads", 32'(q.size()), 32'(PRE + 8));
        chk("old_row1", q[q.size() - 8], 32'h01A5013C);
        chk("old_row8", q[q.size() - 1], 32'h08110822);
        q.delete();
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        wait_idle(cyc);
        chk("new_loads", 32'(q.size()), 32'(PRE + 8));
        chk("new_row1", q[q.size() - 8], 32'h01010100);
        chk("new_row8", q[q.size() - 1], 32'h08FF0880);

        // Reset asserted in the middle of a row transaction.
        start_frame(vecs[0].data, 4'h0);
        cyc = 0;
        while (!(q.size() == PRE && mon_bits == 17) && cyc < 6000) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("reach_bit17", 32'(mon_bits), 32'd17);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_clock", 32'(out_clock), 32'd0);
        chk("mid_rst_load", 32'(out_load), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clock);
        chk("no_partial_load", 32'(q.size()), 32'(PRE));
        bus.in_intensity = 4'h5;
        q.delete();
        reset_n = 1'b1;
        check_init(4'h5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
